instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/instr_pack.sv | 48 ++++
 rtl/instr_encoder.sv | 107 ++++++++++
 tb/tb_instr_encoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: mnemonic enumeration, opcode/funct values and
// field-packing helpers used by the encoder and the instruction decoder.
package mips_pkg;

    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND  = 5'd2,  MN_OR   = 5'd3,
        MN_XOR  = 5'd4,  MN_NOR  = 5'd5,  MN_SLT  = 5'd6,  MN_SLL  = 5'd7,
        MN_SRL  = 5'd8,  MN_JR   = 5'd9,  MN_JALR = 5'd10, MN_ADDI = 5'd11,
        MN_ANDI = 5'd12, MN_SLTI = 5'd13, MN_BEQ  = 5'd14, MN_BNE  = 5'd15,
        MN_LW   = 5'd16, MN_SW   = 5'd17, MN_LH   = 5'd18, MN_SH   = 5'd19,
        MN_J    = 5'd20, MN_JAL  = 5'd21
    } mnem_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational MIPS field packer: maps a mnemonic plus operand fields to a
// 32-bit instruction word, flagging mnemonic codes outside the defined set.
module instr_pack
    import mips_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (mnem)
            MN_ADD:  word = r_word(rs, rt, rd, shamt, FN_ADD);
            MN_SUB:  word = r_word(rs, rt, rd, shamt, FN_SUB);
            MN_AND:  word = r_word(rs, rt, rd, shamt, FN_AND);
            MN_OR:   word = r_word(rs, rt, rd, shamt, FN_OR);
            MN_XOR:  word = r_word(rs, rt, rd, shamt, FN_XOR);
            MN_NOR:  word = r_word(rs, rt, rd, shamt, FN_NOR);
            MN_SLT:  word = r_word(rs, rt, rd, shamt, FN_SLT);
            // Shifts take their operand from rt; rs is architecturally zero
            MN_SLL:  word = r_word(5'd0, rt, rd, shamt, FN_SLL);
            MN_SRL:  word = r_word(5'd0, rt, rd, shamt, FN_SRL);
            MN_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_JALR: word = r_word(rs, rt, rd, shamt, FN_JALR);
            MN_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
            MN_ANDI: word = i_word(OP_ANDI, rs, rt, imm);
            MN_SLTI: word = i_word(OP_SLTI, rs, rt, imm);
            MN_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
            MN_BNE:  word = i_word(OP_BNE, rs, rt, imm);
            MN_LW:   word = i_word(OP_LW, rs, rt, imm);
            MN_SW:   word = i_word(OP_SW, rs, rt, imm);
            MN_LH:   word = i_word(OP_LH, rs, rt, imm);
            MN_SH:   word = i_word(OP_SH, rs, rt, imm);
            MN_J:    word = j_word(OP_J, target);
            MN_JAL:  word = j_word(OP_JAL, target);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded MIPS instructions into instruction memory: one request per
// accepted handshake, written one cycle later at consecutive word addresses.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [4:0]    mnem,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   wcount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [AW:0]   WCOUNT_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   WCOUNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ONE   = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] addr_cnt;
    logic [31:0]   pack_word;
    logic          pack_illegal;
    logic          accept;
    logic          write_p0;

    instr_pack u_pack (
        .mnem    (mnem),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm),
        .target  (target),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;
    assign write_p0 = accept && !pack_illegal;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && in_last) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request stage -> write stage: the packed word is registered straight
    // into the memory port; counters advance on the same edge so they read
    // their new values during the write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_cnt <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            wcount   <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == DRAIN);
            im_we   <= write_p0;
            if (state_q == IDLE && start) begin
                addr_cnt <= base_addr;
                wcount   <= '0;
                err      <= 1'b0;
            end
            if (write_p0) begin
                im_addr  <= addr_cnt;
                im_wdata <= pack_word;
                addr_cnt <= addr_cnt + ADDR_ONE;
                if (wcount != WCOUNT_MAX) wcount <= wcount + WCOUNT_ONE;
            end
            if (accept && pack_illegal) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a stream-level
// reference model built from lookup tables of MIPS opcodes and functs.
module tb_instr_encoder;

    localparam int AW = 10;
    localparam int ASPAN = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [4:0]    mnem = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0]   imm = '0;
    logic [25:0]   target = '0;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          busy, done, err;
    logic [AW:0]   wcount;

    instr_encoder #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .busy(busy), .done(done), .err(err), .wcount(wcount)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference tables indexed by mnemonic code
    int rfunct [11] = '{32, 34, 36, 37, 38, 39, 42, 0, 2, 8, 9};
    int iop    [9]  = '{8, 12, 10, 4, 5, 35, 43, 33, 41};
    int jop    [2]  = '{2, 3};

    function automatic logic [32:0] model_enc(input int m, input int a_rs, input int a_rt,
                                              input int a_rd, input int a_sh,
                                              input int a_imm, input int a_tgt);
        logic [31:0] w;
        if (m <= 10) begin
            if (m == 7 || m == 8) a_rs = 0;
            if (m == 9) begin a_rt = 0; a_rd = 0; a_sh = 0; end
            w = 32'(a_rs * (1 << 21) + a_rt * (1 << 16) + a_rd * (1 << 11) + a_sh * 64 + rfunct[m]);
        end else if (m <= 19) begin
            w = 32'(iop[m-11] * (1 << 26) + a_rs * (1 << 21) + a_rt * (1 << 16) + a_imm);
        end else if (m <= 21) begin
            w = 32'(jop[m-20] * (1 << 26) + a_tgt);
        end else begin
            return 33'd0;
        end
        return {1'b1, w};
    endfunction

    // Stream-level model: open = accepting requests, closing = last request seen
    bit          m_open, m_closing;
    int          m_addr;
    bit          exp_we, exp_done, exp_err;
    int          exp_addr, exp_wcount;
    logic [31:0] exp_data;

    task automatic model_reset();
        m_open = 0; m_closing = 0; m_addr = 0;
        exp_we = 0; exp_done = 0; exp_err = 0; exp_addr = 0; exp_wcount = 0; exp_data = '0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            exp_we   = 0;
            exp_done = m_closing;
            if (m_closing) begin
                m_closing = 0;
            end else if (m_open) begin
                if (in_valid) begin
                    e = model_enc(int'(mnem), int'(rs), int'(rt), int'(rd), int'(shamt),
                                  int'(imm), int'(target));
                    if (e[32]) begin
                        exp_we     = 1;
                        exp_addr   = m_addr;
                        exp_data   = e[31:0];
                        m_addr     = (m_addr + 1) % ASPAN;
                        exp_wcount = (exp_wcount < ASPAN) ? exp_wcount + 1 : ASPAN;
                    end else begin
                        exp_err = 1;
                    end
                    if (in_last) begin
                        m_open = 0;
                        m_closing = 1;
                    end
                end
            end else if (start) begin
                m_open = 1; m_addr = int'(base_addr); exp_wcount = 0; exp_err = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("im_we", 64'(im_we), 64'(exp_we));
        chk("im_addr", 64'(im_addr), 64'(exp_addr));
        chk("im_wdata", 64'(im_wdata), 64'(exp_data));
        chk("busy", 64'(busy), 64'(m_open || m_closing));
        chk("in_ready", 64'(in_ready), 64'(m_open));
        chk("done", 64'(done), 64'(exp_done));
        chk("err", 64'(err), 64'(exp_err));
        chk("wcount", 64'(wcount), 64'(exp_wcount));
    end

    int          log_addr[$];
    logic [31:0] log_data[$];
    always @(negedge clk) if (im_we === 1'b1) begin
        log_addr.push_back(int'(im_addr));
        log_data.push_back(im_wdata);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input int b);
        start = 1'b1;
        base_addr = AW'(b);
        step();
        start = 1'b0;
    endtask

    task automatic send(input int m, input int a_rs, input int a_rt, input int a_rd,
                        input int a_sh, input int a_imm, input int a_tgt, input bit last);
        in_valid = 1'b1; in_last = last;
        mnem = 5'(m); rs = 5'(a_rs); rt = 5'(a_rt); rd = 5'(a_rd); shamt = 5'(a_sh);
        imm = 16'(a_imm); target = 26'(a_tgt);
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        model_reset();
        step(); step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_wcount", 64'(wcount), 64'd0);
        rst_n = 1'b1;

        // single add, base 0x010
        clear_log();
        do_start(16'h010);
        send(0, 1, 2, 3, 0, 0, 0, 1'b1);
        chk("s1_wcount", 64'(wcount), 64'd1);
        step();
        chk("s1_done", 64'(done), 64'd1);
        chk("s1_nwrites", 64'(log_addr.size()), 64'd1);
        if (log_addr.size() == 1) begin
            chk("s1_addr", 64'(log_addr[0]), 64'h010);
            chk("s1_data", 64'(log_data[0]), 64'h00221820);
        end
        step();

        // addi / j / lw stream
        clear_log();
        do_start(16'h040);
        send(11, 0, 4, 0, 0, 16'hFFFF, 0, 1'b0);
        send(20, 0, 0, 0, 0, 0, 26'h40, 1'b0);
        send(16, 29, 8, 0, 0, 4, 0, 1'b1);
        step(); step();
        chk("s2_nwrites", 64'(log_addr.size()), 64'd3);
        if (log_addr.size() == 3) begin
            chk("s2_data0", 64'(log_data[0]), 64'h2004FFFF);
            chk("s2_data1", 64'(log_data[1]), 64'h08000040);
            chk("s2_data2", 64'(log_data[2]), 64'h8FA80004);
            chk("s2_addr2", 64'(log_addr[2]), 64'h042);
        end

        // illegal mnemonic between two legal requests
        clear_log();
        do_start(16'h100);
        send(0, 1, 2, 3, 0, 0, 0, 1'b0);
        send(25, 1, 2, 3, 0, 0, 0, 1'b0);
        send(1, 4, 5, 6, 0, 0, 0, 1'b1);
        step(); step();
        chk("s3_err", 64'(err), 64'd1);
        chk("s3_nwrites", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2) chk("s3_addr1", 64'(log_addr[1]), 64'h101);

        // address wrap
        clear_log();
        do_start(16'h3FF);
        send(2, 1, 1, 1, 0, 0, 0, 1'b0);
        send(3, 2, 2, 2, 0, 0, 0, 1'b1);
        step(); step();
        chk("s4_err_cleared", 64'(err), 64'd0);
        if (log_addr.size() == 2) begin
            chk("s4_addr0", 64'(log_addr[0]), 64'h3FF);
            chk("s4_addr1", 64'(log_addr[1]), 64'h000);
        end else chk("s4_nwrites", 64'(log_addr.size()), 64'd2);

        // reset right after an accepted request
        clear_log();
        do_start(16'h200);
        in_valid = 1'b1; in_last = 1'b0; mnem = 5'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_we", 64'(im_we), 64'd0);
        chk("rst_wdata", 64'(im_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        step(); step();
        chk("rst_nwrites", 64'(log_addr.size()), 64'd0);
        rst_n = 1'b1;
        do_start(16'h005);
        chk("rst_restart_busy", 64'(busy), 64'd1);
        send(4, 1, 2, 3, 0, 0, 0, 1'b1);
        step(); step();

        // start during RUN and in_valid in IDLE are ignored
        clear_log();
        do_start(16'h020);
        do_start(16'h300);
        send(0, 1, 2, 3, 0, 0, 0, 1'b1);
        step(); step();
        in_valid = 1'b1;
        step();
        chk("s6_ready_idle", 64'(in_ready), 64'd0);
        step(); step();
        in_valid = 1'b0;
        chk("s6_nwrites", 64'(log_addr.size()), 64'd1);
        if (log_addr.size() == 1) chk("s6_addr", 64'(log_addr[0]), 64'h020);

        // wcount saturation over a long stream
        do_start(0);
        for (int i = 0; i < ASPAN + 6; i++) send(i % 22, i % 32, 7, 9, 3, i, i, i == ASPAN + 5);
        chk("sat_wcount", 64'(wcount), 64'(ASPAN));
        step(); step();

        // randomized streams
        for (int s = 0; s < 40; s++) begin
            do_start(int'($urandom_range(0, ASPAN - 1)));
            begin
                int len;
                len = int'($urandom_range(1, 12));
                for (int k = 0; k < len; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        start = 1'($urandom_range(0, 1));
                        base_addr = AW'($urandom);
                        step();
                        start = 1'b0;
                    end
                    send(($urandom_range(0, 9) == 0) ? int'($urandom_range(22, 31))
                                                     : int'($urandom_range(0, 21)),
                         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 65535)), int'($urandom & 32'h03FF_FFFF),
                         k == len - 1);
                end
            end
            repeat ($urandom_range(2, 4)) begin
                in_valid = 1'($urandom_range(0, 1));
                step();
            end
            in_valid = 1'b0;
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
